// File: rtl/note_seq_pkg.sv
// Shared types and defaults for the note sequencer.
//   state_t : sequencer FSM states (IDLE, PLAY, GAP)
//   entry_t : one queued note entry {note, beats}
//   DEF_*   : default parameter values for note_sequencer
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] note;
    logic [3:0] beats;
  } entry_t;

  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_TICK_DIV   = 4194304;
  localparam int unsigned DEF_GAP_CYCLES = 262144;

  // A beat field of 0 encodes the maximum duration of 16 beats.
  function automatic logic [4:0] beats_to_count(input logic [3:0] beats);
    return (beats == 4'd0) ? 5'd16 : {1'b0, beats};
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous FIFO of note entries.
//   CLK, RST_N : clock, async active-low reset
//   push       : write request (ignored when full)
//   wr_data    : entry to write
//   pop        : read request (ignored when empty)
//   head_c     : entry at the read pointer (combinational)
//   level      : number of stored entries
//   full/empty : registered status flags, evaluated before this cycle's push/pop
module note_fifo
  import note_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   push,
  input  entry_t                 wr_data,
  input  logic                   pop,
  output entry_t                 head_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_nxt;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt = level;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers, level and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: queues {note, beats} entries and plays them to a tone
// generator, one beat = TICK_DIV clocks.
//   CLK, RST_N           : clock, async active-low reset
//   in_valid/in_ready    : entry handshake (in_ready = !full)
//   in_note, in_beats    : entry payload (note 0 = rest, beats 0 = 16)
//   play_en              : playback enable
//   note                 : current note to the tone generator (0 = silence)
//   note_active          : an entry is sounding (PLAY state)
//   busy                 : not IDLE
//   fifo_level           : stored entry count
// Macro NOTE_SEQ_GAP_EN: when defined, each note ends with GAP_CYCLES of
// silence inside its slot; otherwise notes are played legato.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_note,
  input  logic [3:0]             in_beats,
  input  logic                   play_en,
  output logic [7:0]             note,
  output logic                   note_active,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned       TICK_W      = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
`ifdef NOTE_SEQ_GAP_EN
  localparam logic [TICK_W-1:0] END_TICK    = TICK_W'(GAP_CYCLES);
`else
  localparam logic [TICK_W-1:0] END_TICK    = '0;
`endif

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("note_sequencer: DEPTH must be a power of two in 4..256");
  end
  if (TICK_DIV < 4) begin : g_bad_tick
    $error("note_sequencer: TICK_DIV must be at least 4");
  end
  if (GAP_CYCLES >= TICK_DIV) begin : g_bad_gap
    $error("note_sequencer: GAP_CYCLES must be less than TICK_DIV");
  end

  state_t            state;
  state_t            state_nxt;
  logic [4:0]        beat;
  logic [4:0]        beat_nxt;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_nxt;
  logic [7:0]        note_nxt;
  logic              start;
  logic              pop;
  logic              full;
  logic              empty;
  entry_t            wr_entry;
  entry_t            head_c;

  assign wr_entry = {in_note, in_beats};
  assign in_ready = !full;

  note_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .push   (in_valid),
    .wr_data(wr_entry),
    .pop    (pop),
    .head_c (head_c),
    .level  (fifo_level),
    .full   (full),
    .empty  (empty)
  );

  // Next-state, counter and note logic; 'start' pops and loads a new entry.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    tick_nxt  = tick;
    note_nxt  = note;
    start     = 1'b0;
    case (state)
      IDLE: start = !empty && play_en;
      PLAY: begin
        if (beat == 5'd1 && tick == END_TICK) begin
`ifdef NOTE_SEQ_GAP_EN
          state_nxt = GAP;
          note_nxt  = '0;
          beat_nxt  = '0;
          tick_nxt  = tick - TICK_W'(1);
`else
          start = !empty && play_en;
          if (!start) begin
            state_nxt = IDLE;
            note_nxt  = '0;
            beat_nxt  = '0;
            tick_nxt  = '0;
          end
`endif
        end else if (tick == '0) begin
          tick_nxt = TICK_RELOAD;
          beat_nxt = beat - 5'd1;
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
`ifdef NOTE_SEQ_GAP_EN
      // Tick keeps counting down through the gap; tick==0 is its last cycle.
      GAP: begin
        if (tick == '0) begin
          start = !empty && play_en;
          if (!start) state_nxt = IDLE;
        end else begin
          tick_nxt = tick - TICK_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt = PLAY;
      note_nxt  = head_c.note;
      beat_nxt  = beats_to_count(head_c.beats);
      tick_nxt  = TICK_RELOAD;
    end
    pop = start;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      beat        <= '0;
      tick        <= '0;
      note        <= '0;
      note_active <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat        <= beat_nxt;
      tick        <= tick_nxt;
      note        <= note_nxt;
      note_active <= (state_nxt == PLAY);
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (DEPTH=4, TICK_DIV=8, GAP_CYCLES=2).
// The reference model expands each entry into its slot of beats*TICK_DIV
// cycles: sounding for slot-gap cycles, silent for the gap, back to back.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned TICK_DIV   = 8;
  localparam int unsigned GAP_CYCLES = 2;
`ifdef NOTE_SEQ_GAP_EN
  localparam int GAP_LEN = GAP_CYCLES;
`else
  localparam int GAP_LEN = 0;
`endif

  typedef logic [9:0] vec_t;   // {note, note_active, busy}
  typedef vec_t vec_q_t[$];

  logic       CLK;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_note;
  logic [3:0] in_beats;
  logic       play_en;
  logic [7:0] note;
  logic       note_active;
  logic       busy;
  logic [2:0] fifo_level;

  int checks   = 0;
  int failures = 0;

  note_sequencer #(
    .DEPTH     (DEPTH),
    .TICK_DIV  (TICK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_note    (in_note),
    .in_beats   (in_beats),
    .play_en    (play_en),
    .note       (note),
    .note_active(note_active),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic entry_t mk(input int n, input int b);
    entry_t e;
    e.note  = 8'(n);
    e.beats = 4'(b);
    return e;
  endfunction

  // Expected per-cycle outputs from the first sounding cycle, plus 3 idle cycles.
  function automatic vec_q_t build_trace(input entry_t q[$]);
    vec_q_t t;
    int     slot;
    foreach (q[i]) begin
      slot = ((q[i].beats == 4'd0) ? 16 : int'(q[i].beats)) * TICK_DIV;
      for (int k = 0; k < slot; k++) begin
        if (k < slot - GAP_LEN) t.push_back({q[i].note, 2'b11});
        else                    t.push_back(10'b00000000_01);
      end
    end
    repeat (3) t.push_back(10'd0);
    return t;
  endfunction

  // Offer entries on consecutive cycles; called just after a rising edge.
  task automatic push_entries(input entry_t q[$]);
    foreach (q[i]) begin
      in_valid = 1'b1;
      in_note  = q[i].note;
      in_beats = q[i].beats;
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if ({note, note_active, busy, fifo_level} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs: got note=%0d act=%b busy=%b level=%0d required all 0",
               note, note_active, busy, fifo_level);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: got ready=%b level=%0d busy=%b required 1/0/0",
               in_ready, fifo_level, busy);
    end
  endtask

  task automatic test_single_notes();
    entry_t tbl[4];
    tbl[0] = mk(25, 1);
    tbl[1] = mk(30, 0);
    tbl[2] = mk(0, 1);
    tbl[3] = mk(200, 3);
    play_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      entry_t q[$];
      vec_q_t exp_q;
      q.push_back(tbl[i]);
      exp_q = build_trace(q);
      @(posedge CLK);
      #1;
      fork
        push_entries(q);
        begin
          repeat (2) @(posedge CLK);
          foreach (exp_q[k]) begin
            @(negedge CLK);
            checks++;
            if ({note, note_active, busy} !== exp_q[k]) begin
              failures++;
              $display("FAIL single[%0d] cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                       i, k, note, note_active, busy, exp_q[k][9:2], exp_q[k][1], exp_q[k][0]);
            end
          end
        end
      join
    end
  endtask

  task automatic test_back_to_back();
    entry_t q[$];
    vec_q_t exp_q;
    q.push_back(mk(25, 2));
    q.push_back(mk(27, 1));
    exp_q = build_trace(q);
    play_en = 1'b1;
    @(posedge CLK);
    #1;
    fork
      push_entries(q);
      begin
        repeat (2) @(posedge CLK);
        foreach (exp_q[k]) begin
          @(negedge CLK);
          checks++;
          if ({note, note_active, busy} !== exp_q[k]) begin
            failures++;
            $display("FAIL back_to_back cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                     k, note, note_active, busy, exp_q[k][9:2], exp_q[k][1], exp_q[k][0]);
          end
        end
      end
    join
  endtask

  task automatic test_full_fifo();
    entry_t q[$];
    vec_q_t exp_q;
    for (int i = 0; i < 4; i++) q.push_back(mk(40 + i, 1));
    exp_q = build_trace(q);
    play_en = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_note  = 8'(40 + i);
      in_beats = 4'd1;
      @(negedge CLK);
      checks++;
      if (in_ready !== 1'(i < 4)) begin
        failures++;
        $display("FAIL full_in_ready[%0d]: got %b required %b", i, in_ready, 1'(i < 4));
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_level: got level=%0d ready=%b required 4/0", fifo_level, in_ready);
    end
    @(posedge CLK);
    #1;
    play_en = 1'b1;
    @(negedge CLK);
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL pop_cycle_level: got %0d required 4", fifo_level);
    end
    foreach (exp_q[k]) begin
      @(negedge CLK);
      if (k == 0) begin
        checks++;
        if (fifo_level !== 3'd3) begin
          failures++;
          $display("FAIL after_pop_level: got %0d required 3", fifo_level);
        end
      end
      checks++;
      if ({note, note_active, busy} !== exp_q[k]) begin
        failures++;
        $display("FAIL full_drain cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                 k, note, note_active, busy, exp_q[k][9:2], exp_q[k][1], exp_q[k][0]);
      end
    end
    checks++;
    if (fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL drained_level: got level=%0d ready=%b required 0/1", fifo_level, in_ready);
    end
  endtask

  task automatic test_play_en_drop();
    entry_t q[$];
    entry_t q0[$];
    entry_t q1[$];
    vec_q_t exp0;
    vec_q_t exp1;
    q.push_back(mk(50, 2));
    q.push_back(mk(51, 1));
    q0.push_back(q[0]);
    q1.push_back(q[1]);
    exp0 = build_trace(q0);
    exp1 = build_trace(q1);
    play_en = 1'b1;
    @(posedge CLK);
    #1;
    fork
      push_entries(q);
      begin
        repeat (3) @(posedge CLK);
        #1;
        play_en = 1'b0;
      end
      begin
        repeat (2) @(posedge CLK);
        foreach (exp0[k]) begin
          @(negedge CLK);
          checks++;
          if ({note, note_active, busy} !== exp0[k]) begin
            failures++;
            $display("FAIL drop_first cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                     k, note, note_active, busy, exp0[k][9:2], exp0[k][1], exp0[k][0]);
          end
        end
      end
    join
    checks++;
    if (fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL drop_held_level: got %0d required 1", fifo_level);
    end
    @(posedge CLK);
    #1;
    play_en = 1'b1;
    @(posedge CLK);
    foreach (exp1[k]) begin
      @(negedge CLK);
      checks++;
      if ({note, note_active, busy} !== exp1[k]) begin
        failures++;
        $display("FAIL drop_resume cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                 k, note, note_active, busy, exp1[k][9:2], exp1[k][1], exp1[k][0]);
      end
    end
  endtask

  task automatic test_random();
    play_en = 1'b1;
    for (int it = 0; it < 8; it++) begin
      entry_t q[$];
      vec_q_t exp_q;
      int     n;
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++)
        q.push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 4))));
      exp_q = build_trace(q);
      @(posedge CLK);
      #1;
      fork
        push_entries(q);
        begin
          repeat (2) @(posedge CLK);
          foreach (exp_q[k]) begin
            @(negedge CLK);
            checks++;
            if ({note, note_active, busy} !== exp_q[k]) begin
              failures++;
              $display("FAIL random[%0d] cycle %0d: got note=%0d act=%b busy=%b required note=%0d act=%b busy=%b",
                       it, k, note, note_active, busy, exp_q[k][9:2], exp_q[k][1], exp_q[k][0]);
            end
          end
        end
      join
    end
  endtask

  task automatic test_reset_mid_play();
    entry_t q[$];
    for (int i = 0; i < 4; i++) q.push_back(mk(60 + i, 2));
    play_en = 1'b1;
    @(posedge CLK);
    #1;
    push_entries(q);
    @(negedge CLK);
    checks++;
    if (note !== 8'd60 || fifo_level !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset: got note=%0d level=%0d required 60/3", note, fifo_level);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({note, note_active, busy, fifo_level} !== 13'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got note=%0d act=%b busy=%b level=%0d ready=%b required 0/0/0/0/1",
               note, note_active, busy, fifo_level, in_ready);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      checks++;
      if ({note, note_active, busy, fifo_level} !== 13'd0) begin
        failures++;
        $display("FAIL post_reset cycle %0d: got note=%0d act=%b busy=%b level=%0d required all 0",
                 k, note, note_active, busy, fifo_level);
      end
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    in_valid = 1'b0;
    in_note  = 8'd0;
    in_beats = 4'd0;
    play_en  = 1'b0;
    test_reset();
    test_single_notes();
    test_back_to_back();
    test_full_fifo();
    test_play_en_drop();
    test_random();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, 4 to 256.
REQ-002 SHALL have parameter TICK_DIV, default 4194304: clocks per beat; at least 4.
REQ-003 SHALL have parameter GAP_CYCLES, default 262144: articulation silence per note; less than TICK_DIV.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: a note entry is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: an entry can be accepted; equals !full.
REQ-008 SHALL have port in_note, input, 8 bits: full note number for the tone generator; 0 means rest.
REQ-009 SHALL have port in_beats, input, 4 bits: duration in beats; 0 means 16.
REQ-010 SHALL have port play_en, input, 1 bit: playback enable.
REQ-011 SHALL have port note, output, 8 bits: current full note to the tone generator; 0 means silence.
REQ-012 SHALL have port note_active, output, 1 bit: a sequenced entry is sounding (state PLAY).
REQ-013 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port fifo_level, output, $clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-015 SHALL accept an entry {in_note, in_beats} on a cycle with in_valid && in_ready.
REQ-016 SHALL deassert in_ready when full, including on a pop cycle; no bypass.
REQ-017 SHALL use states IDLE, PLAY and GAP.
REQ-018 In IDLE with the FIFO non-empty and play_en=1, SHALL pop one entry; it goes to PLAY and note updates on the next cycle.
REQ-019 On entering PLAY, SHALL load the beat counter (5 bits) with the beat count (16 if in_beats=0) and the tick counter with TICK_DIV-1.
REQ-020 In PLAY, the tick counter SHALL decrement each cycle; on reaching 0 it reloads and the beat counter decrements.
REQ-021 PLAY SHALL exit when beat=1 and tick=GAP_CYCLES; note becomes 0 and the state goes to GAP for exactly GAP_CYCLES cycles.
REQ-022 Each entry's total slot SHALL be beats*TICK_DIV cycles: note held for beats*TICK_DIV-GAP_CYCLES cycles, then silence.
REQ-023 On the last GAP cycle, if the FIFO is non-empty and play_en=1, SHALL pop directly, with no IDLE cycle; otherwise it goes to IDLE.
REQ-024 If play_en drops mid-note, SHALL finish the current entry, including its gap, then hold in IDLE.
REQ-025 A rest entry (in_note=0) SHALL occupy its full slot with note=0 and note_active=1.
REQ-026 fifo_level SHALL be unchanged on a simultaneous push and pop; read and write pointers wrap modulo DEPTH.
REQ-027 A push on the pop cycle into an empty FIFO SHALL be impossible to pop that cycle; empty is evaluated before the push.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, pointers 0, fifo_level 0, note 0, note_active 0, busy 0 and counters 0, regardless of state.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Reset mid-note SHALL discard all queued entries.

Configuration
REQ-031 SHALL support macro NOTE_SEQ_GAP_EN.
REQ-032 With NOTE_SEQ_GAP_EN defined, REQ-021 to REQ-023 SHALL apply.
REQ-033 Without NOTE_SEQ_GAP_EN, the GAP state and GAP_CYCLES logic SHALL be absent (legato).
REQ-034 Without NOTE_SEQ_GAP_EN, PLAY SHALL end at beat=1, tick=0; note is held for the full beats*TICK_DIV cycles, and the next pop happens on that last PLAY cycle.

Structure
REQ-035 Package note_seq_pkg SHALL hold the state enum (IDLE, PLAY, GAP), the entry struct {note[7:0], beats[3:0]} and the default DEPTH, TICK_DIV and GAP_CYCLES constants.
REQ-036 Sub-module note_fifo SHALL implement the synchronous FIFO (storage, pointers, level, full, empty); the FSM and counters stay in note_sequencer.

Verification (bench: TICK_DIV=8, GAP_CYCLES=2, DEPTH=4)
REQ-037 Push {25,1} with play_en=1 -> note=25 for 6 cycles starting 1 cycle after the pop, then 0 for 2 cycles, then IDLE with busy=0.
REQ-038 Push {25,2},{27,1} back-to-back -> note=25 for 14 cycles, 0 for 2, then 27 on the very next cycle with no IDLE gap.
REQ-039 Push 5 entries with play_en=0 -> in_ready=0 after the 4th push, 5th not accepted, fifo_level=4; raise play_en -> level drops to 3 one cycle later.
REQ-040 Push {30,0} -> note=30 for 126 cycles (16 beats).
REQ-041 Push {0,1} -> note=0 and note_active=1 for 6 cycles.
REQ-042 Assert RST_N=0 mid-PLAY with 3 entries queued -> note=0, fifo_level=0, busy=0 asynchronously; no playback after release.
